// File: rtl/srdl_pkg.sv
// Shared types and constants for the SystemRDL software access engine.
// The index-width helper keeps a one-register block at a 1-bit index.
package srdl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } srdl_acc_state_e;

    localparam logic SRDL_RESP_OK  = 1'b0;
    localparam logic SRDL_RESP_ERR = 1'b1;

    function automatic int srdl_idx_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/srdl_addr_decode.sv
// Combinational byte-address to register-index decoder.
// Arithmetic is one bit wider than the address so that addresses below BASE borrow into the MSB and miss.
module srdl_addr_decode
    import srdl_pkg::*;
#(
    parameter int AW          = 16,
    parameter int NREGS       = 8,
    parameter int BASE        = 0,
    parameter int STRIDE_LOG2 = 2
) (
    input  logic [AW-1:0]                addr,
    output logic                         hit,
    output logic [srdl_idx_w(NREGS)-1:0] idx
);

    localparam int          IW       = srdl_idx_w(NREGS);
    localparam int          AWX      = AW + 1;
    localparam logic [AW:0] BASE_X   = AWX'(BASE);
    localparam logic [AW:0] LOW_MASK = AWX'((1 << STRIDE_LOG2) - 1);
    localparam logic [AW:0] NREGS_X  = AWX'(NREGS);

    logic [AW:0] off;
    logic [AW:0] slot;

    assign off  = {1'b0, addr} - BASE_X;
    assign slot = off >> STRIDE_LOG2;
    assign hit  = !off[AW] && ((off & LOW_MASK) == '0) && (slot < NREGS_X);
    assign idx  = slot[IW-1:0];

endmodule

// File: rtl/srdl_reg_access.sv
// Single-beat register access engine: IDLE accepts, ACCESS fires one strobe cycle
// and captures the pre-access value, RESP holds the response until consumed.
module srdl_reg_access
    import srdl_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 16,
    parameter int NREGS       = 8,
    parameter int BASE        = 0,
    parameter int STRIDE_LOG2 = 2,
    parameter int ERR_ON_MISS = 1
) (
    input  logic                clk,
    input  logic                rst,
    // Both channels: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends combinationally on ready.
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AW-1:0]       req_addr,
    input  logic [DW-1:0]       req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DW-1:0]       resp_rdata,
    output logic                resp_err,
    output logic [NREGS-1:0]    reg_acc,
    output logic [NREGS-1:0]    reg_rd,
    output logic [NREGS-1:0]    reg_wr,
    output logic [DW-1:0]       reg_wdata,
    input  logic [NREGS*DW-1:0] reg_rdata,
    output srdl_acc_state_e     dbg_state
);

    localparam int IW = srdl_idx_w(NREGS);

    srdl_acc_state_e state;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic            hit;
    logic [IW-1:0]   idx;
    logic [NREGS-1:0] sel;
    logic [DW-1:0]   rd_sel;

    srdl_addr_decode #(
        .AW          (AW),
        .NREGS       (NREGS),
        .BASE        (BASE),
        .STRIDE_LOG2 (STRIDE_LOG2)
    ) u_decode (
        .addr (addr_q),
        .hit  (hit),
        .idx  (idx)
    );

    always_comb begin
        sel    = '0;
        rd_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == IW'(i)) begin
                sel[i] = hit;
                rd_sel = reg_rdata[i*DW +: DW];
            end
        end
    end

    // Strobes are decoded from state so they last exactly the one ACCESS cycle.
    assign req_ready = (state == IDLE) && !rst;
    assign reg_acc   = ((state == ACCESS) && !rst) ? sel : '0;
    assign reg_rd    = wr_q ? '0 : reg_acc;
    assign reg_wr    = wr_q ? reg_acc : '0;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            reg_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= SRDL_RESP_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        reg_wdata <= req_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= (hit && !wr_q) ? rd_sel : '0;
                    if (hit) begin
                        resp_err <= SRDL_RESP_OK;
                    end else begin
                        resp_err <= (ERR_ON_MISS != 0) ? SRDL_RESP_ERR : SRDL_RESP_OK;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
